// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_ctrl_pkg : shared types for the pipeline hazard controller      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pipe_ctrl_pkg;

  // Tracker rd is stored at this width; REG_ADDR_W must not exceed it.
  localparam int TRK_RD_W = 8;

  localparam logic [TRK_RD_W-1:0] ZERO_REG = '0;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic                valid;
    logic                regwrite;
    logic                is_load;
    logic [TRK_RD_W-1:0] rd;
  } trk_t;

endpackage
`default_nettype wire

// File: rtl/hazard_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_cmp : RAW check of the ID sources against one stage tracker   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hazard_cmp
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_ONLY = 0
) (
  input  logic                use1_i,
  input  logic                use2_i,
  input  logic [TRK_RD_W-1:0] rs1_i,
  input  logic [TRK_RD_W-1:0] rs2_i,
  input  trk_t                trk_i,
  output logic                hit_o
);

  logic w_writer;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // With LOAD_ONLY set, only a load in this stage is a hazard (the rest forward).
  assign w_writer  = trk_i.valid && trk_i.regwrite &&
                     ((LOAD_ONLY != 0) ? trk_i.is_load : 1'b1);
  assign w_rs1_hit = use1_i && (rs1_i != ZERO_REG) && (trk_i.rd == rs1_i);
  assign w_rs2_hit = use2_i && (rs2_i != ZERO_REG) && (trk_i.rd == rs2_i);
  assign hit_o     = w_writer && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_hazard_ctrl : stall/flush/freeze control for 5-stage pipe   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FORWARDING = 1,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  IDValid,
  input  logic [REG_ADDR_W-1:0] IDrs1,
  input  logic [REG_ADDR_W-1:0] IDrs2,
  input  logic                  IDUsesRs1,
  input  logic                  IDUsesRs2,
  input  logic [REG_ADDR_W-1:0] IDrd,
  input  logic                  IDRegWrite,
  input  logic                  IDIsLoad,
  input  logic                  EXBranchTaken,
  input  logic                  MemReq,
  input  logic                  MemAck,
  output logic                  PCWrite,
  output logic                  IFIDWrite,
  output logic                  IFIDFlush,
  output logic                  IDEXWrite,
  output logic                  IDEXFlush,
  output logic                  EXMEMWrite,
  output logic [CNT_W-1:0]      StallCycles
);

  state_e           state_q, state_d;
  trk_t             ex_q, ex_d;
  trk_t             mem_q, mem_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic w_freeze, w_loaduse, w_ex_hit, w_mem_hit, w_use1, w_use2;
  logic [TRK_RD_W-1:0] w_rs1, w_rs2;

  assign w_use1 = IDValid && IDUsesRs1;
  assign w_use2 = IDValid && IDUsesRs2;
  assign w_rs1  = TRK_RD_W'(IDrs1);
  assign w_rs2  = TRK_RD_W'(IDrs2);

  hazard_cmp #(.LOAD_ONLY(FORWARDING)) u_cmp_ex (
    .use1_i (w_use1),
    .use2_i (w_use2),
    .rs1_i  (w_rs1),
    .rs2_i  (w_rs2),
    .trk_i  (ex_q),
    .hit_o  (w_ex_hit)
  );

  hazard_cmp #(.LOAD_ONLY(0)) u_cmp_mem (
    .use1_i (w_use1),
    .use2_i (w_use2),
    .rs1_i  (w_rs1),
    .rs2_i  (w_rs2),
    .trk_i  (mem_q),
    .hit_o  (w_mem_hit)
  );

  assign w_loaduse = (FORWARDING != 0) ? w_ex_hit : (w_ex_hit || w_mem_hit);
  // The ack cycle of a waited access is a normal RUN cycle.
  assign w_freeze  = (state_q == RUN) ? (MemReq && !MemAck) : !MemAck;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (MemReq && !MemAck) state_d = MEM_WAIT;
      MEM_WAIT: if (MemAck) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXWrite  = 1'b1;
    IDEXFlush  = 1'b0;
    EXMEMWrite = 1'b1;
    if (!RST_N) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IFIDFlush  = 1'b1;
      IDEXWrite  = 1'b0;
      IDEXFlush  = 1'b1;
      EXMEMWrite = 1'b0;
    end else if (w_freeze) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXWrite  = 1'b0;
      EXMEMWrite = 1'b0;
    end else if (EXBranchTaken) begin
      IFIDFlush  = 1'b1;
      IDEXFlush  = 1'b1;
    end else if (w_loaduse) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXFlush  = 1'b1;
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    if (IDEXWrite) begin
      ex_d.valid    = IDValid && !IDEXFlush;
      ex_d.regwrite = IDRegWrite;
      ex_d.is_load  = IDIsLoad;
      ex_d.rd       = TRK_RD_W'(IDrd);
    end
    if (EXMEMWrite) mem_d = ex_q;
  end

  always_comb begin
    stall_d = stall_q;
    if ((w_freeze || (w_loaduse && !EXBranchTaken)) && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      stall_q <= stall_d;
    end
  end

  assign StallCycles = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl : scoreboard bench for pipeline_hazard_ctrl  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

  // Control vector order: {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, EXMEMWrite}
  localparam logic [5:0] C_RSTV = 6'b001010;
  localparam logic [5:0] C_NORM = 6'b110101;
  localparam logic [5:0] C_FRZ  = 6'b000000;
  localparam logic [5:0] C_BR   = 6'b111111;
  localparam logic [5:0] C_LU   = 6'b000111;

  logic       CLK;
  logic       RST_N;
  logic       IDValid, IDUsesRs1, IDUsesRs2, IDRegWrite, IDIsLoad;
  logic [4:0] IDrs1, IDrs2, IDrd;
  logic       EXBranchTaken, MemReq, MemAck;

  wire [5:0]  ctl0, ctl1, ctl2;
  wire [31:0] cnt0, cnt1;
  wire [3:0]  cnt2;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl dut0 (
    .CLK(CLK), .RST_N(RST_N), .IDValid(IDValid), .IDrs1(IDrs1), .IDrs2(IDrs2),
    .IDUsesRs1(IDUsesRs1), .IDUsesRs2(IDUsesRs2), .IDrd(IDrd), .IDRegWrite(IDRegWrite),
    .IDIsLoad(IDIsLoad), .EXBranchTaken(EXBranchTaken), .MemReq(MemReq), .MemAck(MemAck),
    .PCWrite(ctl0[5]), .IFIDWrite(ctl0[4]), .IFIDFlush(ctl0[3]), .IDEXWrite(ctl0[2]),
    .IDEXFlush(ctl0[1]), .EXMEMWrite(ctl0[0]), .StallCycles(cnt0)
  );

  pipeline_hazard_ctrl #(.FORWARDING(0)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .IDValid(IDValid), .IDrs1(IDrs1), .IDrs2(IDrs2),
    .IDUsesRs1(IDUsesRs1), .IDUsesRs2(IDUsesRs2), .IDrd(IDrd), .IDRegWrite(IDRegWrite),
    .IDIsLoad(IDIsLoad), .EXBranchTaken(EXBranchTaken), .MemReq(MemReq), .MemAck(MemAck),
    .PCWrite(ctl1[5]), .IFIDWrite(ctl1[4]), .IFIDFlush(ctl1[3]), .IDEXWrite(ctl1[2]),
    .IDEXFlush(ctl1[1]), .EXMEMWrite(ctl1[0]), .StallCycles(cnt1)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .IDValid(IDValid), .IDrs1(IDrs1), .IDrs2(IDrs2),
    .IDUsesRs1(IDUsesRs1), .IDUsesRs2(IDUsesRs2), .IDrd(IDrd), .IDRegWrite(IDRegWrite),
    .IDIsLoad(IDIsLoad), .EXBranchTaken(EXBranchTaken), .MemReq(MemReq), .MemAck(MemAck),
    .PCWrite(ctl2[5]), .IFIDWrite(ctl2[4]), .IFIDFlush(ctl2[3]), .IDEXWrite(ctl2[2]),
    .IDEXFlush(ctl2[1]), .EXMEMWrite(ctl2[0]), .StallCycles(cnt2)
  );

  // Scoreboard: one expected entry per cycle; count of -1 means "don't check".
  string      q_name[$];
  int         q_sel[$];
  logic [5:0] q_ctl[$];
  int         q_cnt[$];

  int checks = 0;
  int errors = 0;

  string      m_name;
  int         m_sel;
  logic [5:0] m_ctl;
  int         m_cnt;
  logic [5:0] a_ctl;
  logic [31:0] a_cnt;

  always @(negedge CLK) begin
    if (q_sel.size() != 0) begin
      m_name = q_name.pop_front();
      m_sel  = q_sel.pop_front();
      m_ctl  = q_ctl.pop_front();
      m_cnt  = q_cnt.pop_front();
      case (m_sel)
        1:       begin a_ctl = ctl1; a_cnt = cnt1; end
        2:       begin a_ctl = ctl2; a_cnt = {28'd0, cnt2}; end
        default: begin a_ctl = ctl0; a_cnt = cnt0; end
      endcase
      checks++;
      if (a_ctl !== m_ctl) begin
        errors++;
        $display("FAIL %s ctl actual=%b required=%b", m_name, a_ctl, m_ctl);
      end
      if (m_cnt >= 0) begin
        checks++;
        if (a_cnt !== 32'(m_cnt)) begin
          errors++;
          $display("FAIL %s StallCycles actual=%0d required=%0d", m_name, a_cnt, m_cnt);
        end
      end
    end
  end

  task automatic cyc(input string nm, input int sel, input logic [5:0] ctl, input int cnt);
    q_name.push_back(nm);
    q_sel.push_back(sel);
    q_ctl.push_back(ctl);
    q_cnt.push_back(cnt);
    @(posedge CLK);
    #1;
  endtask

  task automatic setid(input logic v, input logic u1, input logic [4:0] r1,
                       input logic u2, input logic [4:0] r2, input logic [4:0] rd,
                       input logic rw, input logic ld);
    IDValid = v; IDUsesRs1 = u1; IDrs1 = r1; IDUsesRs2 = u2; IDrs2 = r2;
    IDrd = rd; IDRegWrite = rw; IDIsLoad = ld;
  endtask

  task automatic idle();
    setid(0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
    EXBranchTaken = 0; MemReq = 0; MemAck = 0;
  endtask

  initial begin
    idle();
    RST_N = 0;
    @(posedge CLK);
    #1;
    // Reset and idle
    cyc("rst_a", 0, C_RSTV, -1);
    cyc("rst_b", 0, C_RSTV, 0);
    RST_N = 1;
    cyc("idle_a", 0, C_NORM, 0);
    cyc("idle_b", 0, C_NORM, 0);
    // Load-use on rs1
    setid(1, 0, 5'd0, 0, 5'd0, 5'd5, 1, 1);  cyc("lu_load", 0, C_NORM, 0);
    setid(1, 1, 5'd5, 0, 5'd0, 5'd6, 1, 0);  cyc("lu_stall", 0, C_LU, 0);
    cyc("lu_issue", 0, C_NORM, 1);
    idle();                                  cyc("lu_after", 0, C_NORM, 1);
    // rd = x0 never hazards
    setid(1, 0, 5'd0, 0, 5'd0, 5'd0, 1, 1);  cyc("x0_load", 0, C_NORM, 1);
    setid(1, 1, 5'd0, 0, 5'd0, 5'd0, 0, 0);  cyc("x0_use", 0, C_NORM, 1);
    idle();                                  cyc("x0_after", 0, C_NORM, 1);
    // Load-use on rs2
    setid(1, 0, 5'd0, 0, 5'd0, 5'd9, 1, 1);  cyc("lu2_load", 0, C_NORM, 1);
    setid(1, 0, 5'd0, 1, 5'd9, 5'd0, 0, 0);  cyc("lu2_stall", 0, C_LU, 1);
    idle();                                  cyc("lu2_after", 0, C_NORM, 2);
    // Branch overrides load-use
    setid(1, 0, 5'd0, 0, 5'd0, 5'd3, 1, 1);  cyc("br_load", 0, C_NORM, 2);
    setid(1, 1, 5'd3, 0, 5'd0, 5'd0, 0, 0);
    EXBranchTaken = 1;                       cyc("br_lu", 0, C_BR, 2);
    idle();                                  cyc("br_after", 0, C_NORM, 2);
    // Multi-cycle memory wait
    MemReq = 1;                              cyc("mw_1", 0, C_FRZ, 2);
    cyc("mw_2", 0, C_FRZ, 3);
    cyc("mw_3", 0, C_FRZ, 4);
    MemAck = 1;                              cyc("mw_ack", 0, C_NORM, 5);
    idle();                                  cyc("mw_after", 0, C_NORM, 5);
    MemReq = 1; MemAck = 1;                  cyc("mw_zero", 0, C_NORM, 5);
    MemReq = 0; MemAck = 1;                  cyc("late_ack", 0, C_NORM, 5);
    idle();                                  cyc("late_after", 0, C_NORM, 5);
    // Freeze masks a branch until the ack cycle
    MemReq = 1; EXBranchTaken = 1;           cyc("frz_br", 0, C_FRZ, 5);
    MemAck = 1;                              cyc("frz_br_ack", 0, C_BR, 6);
    idle();                                  cyc("frz_br_after", 0, C_NORM, 6);
    // Trackers hold while frozen
    setid(1, 0, 5'd0, 0, 5'd0, 5'd4, 1, 1);  cyc("hold_load", 0, C_NORM, 6);
    setid(1, 1, 5'd4, 0, 5'd0, 5'd0, 0, 0);
    MemReq = 1;                              cyc("hold_frz", 0, C_FRZ, 6);
    MemReq = 0; MemAck = 1;                  cyc("hold_lu", 0, C_LU, 7);
    MemAck = 0;                              cyc("hold_issue", 0, C_NORM, 8);
    idle();                                  cyc("hold_after", 0, C_NORM, 8);
    // Reset during MEM_WAIT
    setid(1, 0, 5'd0, 0, 5'd0, 5'd5, 1, 1);  cyc("mr_load", 0, C_NORM, 8);
    idle(); MemReq = 1;                      cyc("mr_frz", 0, C_FRZ, 8);
    MemReq = 0; RST_N = 0;                   cyc("mr_rst", 0, C_RSTV, 9);
    RST_N = 1;
    setid(1, 1, 5'd5, 0, 5'd0, 5'd0, 0, 0);  cyc("mr_run", 0, C_NORM, 0);
    idle();                                  cyc("mr_after", 0, C_NORM, 0);
    // FORWARDING=0: ALU writer stalls the consumer for two cycles
    setid(1, 0, 5'd0, 0, 5'd0, 5'd7, 1, 0);  cyc("nf_alu", 1, C_NORM, 0);
    setid(1, 0, 5'd0, 1, 5'd7, 5'd0, 0, 0);  cyc("nf_ex", 1, C_LU, 0);
    cyc("nf_mem", 1, C_LU, 1);
    cyc("nf_issue", 1, C_NORM, 2);
    idle();                                  cyc("nf_after", 1, C_NORM, 2);
    // Counter saturation on a 4-bit counter
    RST_N = 0;                               cyc("sat_rst", 2, C_RSTV, -1);
    RST_N = 1; MemReq = 1;                   cyc("sat_frz", 2, C_FRZ, 0);
    for (int i = 1; i < 20; i++) cyc("sat_frz", 2, C_FRZ, (i > 15) ? 15 : i);
    MemAck = 1;                              cyc("sat_ack", 2, C_NORM, 15);
    idle();                                  cyc("sat_after", 2, C_NORM, 15);
    @(negedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
